// File: rtl/register_bank_sb_pkg.sv
// Shared constants for the register bank: default geometry and the
// address of the optional hardwired-zero register.
package register_bank_pkg;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 4;
   localparam int ZERO_ADDR  = 0;
endpackage

// File: rtl/register_bank_sb_if.sv
// Bundle of read, write, issue and scoreboard-status signals for register_bank_sb.
// No valid/ready pair: the bank accepts every write/issue each cycle and reads are always valid.
interface register_bank_sb_if
   import register_bank_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
);
   logic [ADDR_W-1:0] RA;
   logic [ADDR_W-1:0] RB;
   logic [DATA_W-1:0] PRA;
   logic [DATA_W-1:0] PRB;
   logic              W_RB;
   logic [ADDR_W-1:0] WC;
   logic [DATA_W-1:0] WPC;
   logic              W_RB2;
   logic [ADDR_W-1:0] WC2;
   logic [DATA_W-1:0] WPC2;
   logic              ISSUE;
   logic [ADDR_W-1:0] ISSUE_RD;
   logic              BUSY_A;
   logic              BUSY_B;
   logic [ADDR_W:0]   PENDING;

   modport master (
      output RA, RB, W_RB, WC, WPC, W_RB2, WC2, WPC2, ISSUE, ISSUE_RD,
      input  PRA, PRB, BUSY_A, BUSY_B, PENDING
   );

   modport slave (
      input  RA, RB, W_RB, WC, WPC, W_RB2, WC2, WPC2, ISSUE, ISSUE_RD,
      output PRA, PRB, BUSY_A, BUSY_B, PENDING
   );
endinterface

// File: rtl/register_bank_sb_scoreboard.sv
// Pending-producer scoreboard: one busy bit per register plus a registered
// population count of the busy bits.
module register_bank_scoreboard #(
   parameter int ADDR_W   = register_bank_pkg::DEF_ADDR_W,
   parameter int ZERO_REG = 0
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              issue_i,
   input  logic [ADDR_W-1:0] issue_rd_i,
   input  logic              w1_i,
   input  logic [ADDR_W-1:0] w1_addr_i,
   input  logic              w2_i,
   input  logic [ADDR_W-1:0] w2_addr_i,
   input  logic [ADDR_W-1:0] ra_i,
   input  logic [ADDR_W-1:0] rb_i,
   output logic              busy_a_o,
   output logic              busy_b_o,
   output logic [ADDR_W:0]   pending_o
);
   import register_bank_pkg::*;

   localparam int DEPTH = 1 << ADDR_W;

   logic [DEPTH-1:0] busy_q, busy_d;
   logic [ADDR_W:0]  pending_q, pending_d;

   // Writes retire a producer; a same-cycle issue re-arms the bit because the new producer wins.
   always_comb begin
      busy_d = busy_q;
      if (w1_i)    busy_d[w1_addr_i]  = 1'b0;
      if (w2_i)    busy_d[w2_addr_i]  = 1'b0;
      if (issue_i) busy_d[issue_rd_i] = 1'b1;
      if (ZERO_REG != 0) busy_d[ZERO_ADDR] = 1'b0;
      pending_d = (ADDR_W+1)'($countones(busy_d));
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         busy_q    <= '0;
         pending_q <= '0;
      end else begin
         busy_q    <= busy_d;
         pending_q <= pending_d;
      end
   end

   assign busy_a_o  = busy_q[ra_i];
   assign busy_b_o  = busy_q[rb_i];
   assign pending_o = pending_q;
endmodule

// File: rtl/register_bank_sb.sv
// Two-read / two-write register bank with a pending-producer scoreboard.
// Optional write-to-read forwarding is enabled by defining REGISTER_BANK_SB_BYPASS_EN.
module register_bank_sb
   import register_bank_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 0
) (
   input logic               CLK,
   input logic               RESET,
   register_bank_sb_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic              w1_ok, w2_ok;
   logic [DATA_W-1:0] pra, prb;

   // Writes to the hardwired-zero register never reach storage.
   assign w1_ok = bus.W_RB  && !(ZERO_REG != 0 && bus.WC  == ADDR_W'(ZERO_ADDR));
   assign w2_ok = bus.W_RB2 && !(ZERO_REG != 0 && bus.WC2 == ADDR_W'(ZERO_ADDR));

   always_comb begin
      regs_d = regs_q;
      if (w1_ok) regs_d[bus.WC]  = bus.WPC;
      if (w2_ok) regs_d[bus.WC2] = bus.WPC2;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      pra = regs_q[bus.RA];
      prb = regs_q[bus.RB];
`ifdef REGISTER_BANK_SB_BYPASS_EN
      // Port 2 is applied last so it takes priority, matching storage.
      if (RESET) begin
         if (w1_ok && bus.WC  == bus.RA) pra = bus.WPC;
         if (w2_ok && bus.WC2 == bus.RA) pra = bus.WPC2;
         if (w1_ok && bus.WC  == bus.RB) prb = bus.WPC;
         if (w2_ok && bus.WC2 == bus.RB) prb = bus.WPC2;
      end
`endif
      if (ZERO_REG != 0 && bus.RA == ADDR_W'(ZERO_ADDR)) pra = '0;
      if (ZERO_REG != 0 && bus.RB == ADDR_W'(ZERO_ADDR)) prb = '0;
   end

   assign bus.PRA = pra;
   assign bus.PRB = prb;

   register_bank_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk_i      (CLK),
      .rst_n_i    (RESET),
      .issue_i    (bus.ISSUE),
      .issue_rd_i (bus.ISSUE_RD),
      .w1_i       (bus.W_RB),
      .w1_addr_i  (bus.WC),
      .w2_i       (bus.W_RB2),
      .w2_addr_i  (bus.WC2),
      .ra_i       (bus.RA),
      .rb_i       (bus.RB),
      .busy_a_o   (bus.BUSY_A),
      .busy_b_o   (bus.BUSY_B),
      .pending_o  (bus.PENDING)
   );
endmodule

// File: tb/tb_register_bank_sb.sv
// Bench for register_bank_sb: one instance with ZERO_REG=0 and one with ZERO_REG=1
// share stimulus; an array/queue reference model predicts every cycle's outputs.
module tb_register_bank_sb;
   localparam int DW = 32;
   localparam int AW = 4;
   localparam int N  = 16;
   localparam int EW = 2*DW + 2 + AW + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          d_rst;
   logic          d_w1, d_w2, d_iss;
   logic [AW-1:0] d_wc, d_wc2, d_ird, d_ra, d_rb;
   logic [DW-1:0] d_wpc, d_wpc2;

   register_bank_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
   register_bank_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

   assign bus0.RA = d_ra;    assign bus1.RA = d_ra;
   assign bus0.RB = d_rb;    assign bus1.RB = d_rb;
   assign bus0.W_RB = d_w1;  assign bus1.W_RB = d_w1;
   assign bus0.WC = d_wc;    assign bus1.WC = d_wc;
   assign bus0.WPC = d_wpc;  assign bus1.WPC = d_wpc;
   assign bus0.W_RB2 = d_w2; assign bus1.W_RB2 = d_w2;
   assign bus0.WC2 = d_wc2;  assign bus1.WC2 = d_wc2;
   assign bus0.WPC2 = d_wpc2; assign bus1.WPC2 = d_wpc2;
   assign bus0.ISSUE = d_iss; assign bus1.ISSUE = d_iss;
   assign bus0.ISSUE_RD = d_ird; assign bus1.ISSUE_RD = d_ird;

   register_bank_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut0 (
      .CLK(clk), .RESET(d_rst), .bus(bus0.slave));
   register_bank_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut1 (
      .CLK(clk), .RESET(d_rst), .bus(bus1.slave));

   // Reference model: contents and pending flags per configuration (index 1 = zero register).
   logic [DW-1:0] m_mem  [2][N];
   bit            m_busy [2][N];

   logic [EW-1:0] exp_q0[$];
   logic [EW-1:0] exp_q1[$];
   int  total = 0;
   int  bad   = 0;
   bit  done    = 1'b0;
   bit  drained = 1'b0;

   function automatic void model_clear();
      for (int z = 0; z < 2; z++)
         for (int i = 0; i < N; i++) begin
            m_mem[z][i]  = '0;
            m_busy[z][i] = 1'b0;
         end
   endfunction

   function automatic logic [DW-1:0] model_read(int z, logic [AW-1:0] a);
      logic [DW-1:0] v;
      v = m_mem[z][a];
`ifdef REGISTER_BANK_SB_BYPASS_EN
      if (d_rst) begin
         if (d_w1 && d_wc == a)  v = d_wpc;
         if (d_w2 && d_wc2 == a) v = d_wpc2;
      end
`endif
      if (z == 1 && a == 0) v = '0;
      return v;
   endfunction

   function automatic logic [EW-1:0] model_exp(int z);
      int cnt;
      cnt = 0;
      for (int i = 0; i < N; i++) cnt += int'(m_busy[z][i]);
      return {model_read(z, d_ra), model_read(z, d_rb),
              logic'(m_busy[z][d_ra]), logic'(m_busy[z][d_rb]), (AW+1)'(cnt)};
   endfunction

   function automatic void model_update(int z);
      if (d_w1 && !(z == 1 && d_wc == 0))  m_mem[z][d_wc]  = d_wpc;
      if (d_w2 && !(z == 1 && d_wc2 == 0)) m_mem[z][d_wc2] = d_wpc2;
      if (d_w1) m_busy[z][d_wc]  = 1'b0;
      if (d_w2) m_busy[z][d_wc2] = 1'b0;
      if (d_iss && !(z == 1 && d_ird == 0)) m_busy[z][d_ird] = 1'b1;
   endfunction

   task automatic check(input int z, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL rd_z%0d t=%0t got pra=%h prb=%h ba=%b bb=%b pend=%0d want pra=%h prb=%h ba=%b bb=%b pend=%0d",
                  z, $time, act[EW-1 -: DW], act[EW-DW-1 -: DW], act[AW+2], act[AW+1], act[AW:0],
                  exp[EW-1 -: DW], exp[EW-DW-1 -: DW], exp[AW+2], exp[AW+1], exp[AW:0]);
      end
   endtask

   // Monitor: outputs are sampled mid-cycle, away from the rising edge.
   always @(negedge clk) begin
      if (exp_q0.size() > 0)
         check(0, {bus0.PRA, bus0.PRB, bus0.BUSY_A, bus0.BUSY_B, bus0.PENDING}, exp_q0.pop_front());
      if (exp_q1.size() > 0)
         check(1, {bus1.PRA, bus1.PRB, bus1.BUSY_A, bus1.BUSY_B, bus1.PENDING}, exp_q1.pop_front());
      if (done && !drained) begin
         drained = 1'b1;
         total++;
         if (exp_q0.size() + exp_q1.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q0.size() + exp_q1.size());
         end
      end
   end

   task automatic idle();
      d_w1 = 1'b0; d_w2 = 1'b0; d_iss = 1'b0;
   endtask

   task automatic rand_inputs();
      d_w1   = 1'($urandom_range(0, 1));
      d_w2   = 1'($urandom_range(0, 1));
      d_iss  = 1'($urandom_range(0, 1));
      d_wc   = AW'($urandom_range(0, N-1));
      d_wc2  = AW'($urandom_range(0, N-1));
      d_ird  = AW'($urandom_range(0, N-1));
      d_ra   = AW'($urandom_range(0, N-1));
      d_rb   = AW'($urandom_range(0, N-1));
      d_wpc  = $urandom();
      d_wpc2 = $urandom();
   endtask

   // One clock cycle: predict this cycle's outputs, then let the edge update the model.
   task automatic step();
      if (!d_rst) model_clear();
      #1;
      exp_q0.push_back(model_exp(0));
      exp_q1.push_back(model_exp(1));
      @(posedge clk);
      if (d_rst) begin
         model_update(0);
         model_update(1);
      end
      #1;
   endtask

   initial begin
      d_rst = 1'b0;
      rand_inputs();
      model_clear();
      @(posedge clk);
      #1;

      // Held in reset with live writes/issues: nothing may change.
      repeat (3) begin rand_inputs(); step(); end
      d_rst = 1'b1; idle(); step();

      // Fill every register through port 1, then read consecutive pairs.
      for (int i = 0; i < N; i++) begin
         idle(); d_w1 = 1'b1; d_wc = AW'(i); d_wpc = $urandom();
         d_ra = AW'($urandom_range(0, N-1)); d_rb = AW'($urandom_range(0, N-1));
         step();
      end
      for (int i = 0; i < N; i++) begin
         idle(); d_ra = AW'(i); d_rb = AW'((i + 1) % N); step();
      end

      // Same-address double write: port 2 wins.
      idle(); d_w1 = 1'b1; d_w2 = 1'b1; d_wc = 4'd5; d_wc2 = 4'd5;
      d_wpc = 32'h1111_1111; d_wpc2 = 32'h2222_2222; d_ra = 4'd5; d_rb = 4'd5;
      step();
      idle(); step();

      // Register 0 write plus issue.
      idle(); d_w1 = 1'b1; d_wc = 4'd0; d_wpc = 32'hDEAD_BEEF; d_iss = 1'b1; d_ird = 4'd0;
      d_ra = 4'd0; d_rb = 4'd0;
      step();
      idle(); step();

      // Issue 3, 7, 3, then issue 3 with a same-cycle write of 3, then retire 7.
      idle(); d_ra = 4'd3; d_rb = 4'd7; d_iss = 1'b1;
      d_ird = 4'd3; step();
      d_ird = 4'd7; step();
      d_ird = 4'd3; step();
      d_w1 = 1'b1; d_wc = 4'd3; d_wpc = $urandom(); step();
      idle(); step();
      d_w1 = 1'b1; d_wc = 4'd7; d_wpc = $urandom(); step();
      idle(); step();

      // Read of a register being written this cycle.
      idle(); d_ra = 4'd9; d_rb = 4'd9; d_w1 = 1'b1; d_wc = 4'd9; d_wpc = 32'hCAFE_F00D; step();
      idle(); step();

      // Randomized traffic with occasional reset pulses.
      repeat (300) begin
         rand_inputs();
         d_rst = ($urandom_range(0, 40) != 0);
         step();
      end
      d_rst = 1'b1;

      // Build non-zero state, then drop reset between edges.
      idle(); d_w1 = 1'b1; d_wc = 4'd2; d_wpc = 32'h1234_5678;
      d_w2 = 1'b1; d_wc2 = 4'd6; d_wpc2 = 32'h8765_4321; step();
      idle(); d_iss = 1'b1; d_ird = 4'd2; step();
      idle(); d_iss = 1'b1; d_ird = 4'd6; d_ra = 4'd2; d_rb = 4'd6; step();
      idle(); step();
      d_rst = 1'b0; step();
      d_rst = 1'b1; step();

      done = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/register_bank_sb.md
REGISTER_BANK_SB -- requirements
Module: register_bank_sb

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 4, address width; depth = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 0; 1 = register 0 hardwired to zero.
REQ-004 CLK  in  1  single clock, all state updates on rising edge.
REQ-005 RESET  in  1  asynchronous, active-low reset.
REQ-006 RA, RB  in  ADDR_W  read addresses, ports A/B.
REQ-007 PRA, PRB  out  DATA_W  read data, ports A/B, combinational.
REQ-008 W_RB, WC, WPC  in  1/ADDR_W/DATA_W  write port 1: enable, address, data.
REQ-009 W_RB2, WC2, WPC2  in  1/ADDR_W/DATA_W  write port 2: enable, address, data.
REQ-010 ISSUE, ISSUE_RD  in  1/ADDR_W  mark destination register pending.
REQ-011 BUSY_A, BUSY_B  out  1  pending bit of RA/RB.
REQ-012 PENDING  out  ADDR_W+1  count of pending registers, registered.

Function
REQ-013 Write port 1 SHALL store WPC into reg[WC] on the rising CLK edge when W_RB=1.
REQ-014 Write port 2 SHALL store WPC2 into reg[WC2] on the rising CLK edge when W_RB2=1.
REQ-015 If both ports write the same address in one cycle, port 2 data SHALL win.
REQ-016 PRA/PRB SHALL equal reg[RA]/reg[RB] with zero-cycle combinational latency.
REQ-017 With ZERO_REG=1, writes to address 0 SHALL be dropped; reads of address 0 SHALL return 0; busy[0] SHALL never set.
REQ-018 ISSUE=1 SHALL set busy[ISSUE_RD] at the clock edge.
REQ-019 Any write (either port) to address n SHALL clear busy[n] at the clock edge.
REQ-020 Simultaneous ISSUE and write to the same address SHALL leave busy set (new producer wins).
REQ-021 ISSUE to an already busy register SHALL be accepted; the bit stays set; PENDING does not change.
REQ-022 BUSY_A/BUSY_B SHALL reflect registered busy bits only; a same-cycle write does not clear them.
REQ-023 PENDING SHALL equal the population count of busy bits after each edge; range 0..2**ADDR_W, no wrap.

Reset
REQ-024 RESET=0 SHALL asynchronously clear all registers, all busy bits and PENDING.
REQ-025 After reset: PRA=PRB=0, BUSY_A=BUSY_B=0, PENDING=0.
REQ-026 Writes and issues asserted while RESET=0 SHALL be ignored; the first update occurs on the first edge with RESET=1.

Configuration
REQ-027 Macro REGISTER_BANK_SB_BYPASS_EN SHALL control write-to-read forwarding.
REQ-028 Macro defined: if a write port targets RA/RB this cycle, PRA/PRB SHALL return that write data combinationally (port 2 priority; ZERO_REG rules still apply).
REQ-029 Macro undefined: PRA/PRB SHALL return stored values only; the written value appears the cycle after the edge.

Structure
REQ-030 Shared package register_bank_pkg SHALL hold default DATA_W/ADDR_W constants and the zero-register address constant.
REQ-031 Scoreboard (busy bits + PENDING counter) SHALL be one sub-module, register_bank_scoreboard; the storage array and read muxes stay in the top module.

Verification
REQ-032 Reset, then write vec[i]=random to regs 0..15 via port 1, read pairs (i, i+1) -> PRA=vec[i], PRB=vec[i+1] (ZERO_REG=0).
REQ-033 W_RB=W_RB2=1, WC=WC2=5, WPC=0x11111111, WPC2=0x22222222 -> reg 5 reads 0x22222222 the next cycle.
REQ-034 ZERO_REG=1, write 0xDEADBEEF to reg 0, ISSUE_RD=0 -> PRA(RA=0)=0, BUSY_A=0, PENDING=0.
REQ-035 ISSUE regs 3,7,3, then write reg 3 with ISSUE_RD=3 in the same cycle -> PENDING 1,2,2,2; BUSY(3)=1; then write reg 7 -> PENDING=1.
REQ-036 Bypass on: RA=9, W_RB=1, WC=9, WPC=0xCAFEF00D in the same cycle -> PRA=0xCAFEF00D before the edge; bypass off -> old value, then new value after the edge.
REQ-037 Pull RESET low between edges with regs and busy bits non-zero -> all outputs 0 immediately, without waiting for a CLK edge.
